// File: rtl/sr_flop_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sr_flop_bank
//  Description : Bank of WIDTH independent clocked set/reset flip-flops with
//                selectable simultaneous set+reset behaviour, registered
//                rise/fall edge pulses, conflict flags, a global clear and a
//                registered population count of the channel state.
//
//  Parameters  : WIDTH      - number of channels (1..64)
//                SIMUL_MODE - set+reset both high: 0 hold, 1 set wins,
//                             2 reset wins, 3 toggle, other = hold
//                CNT_W      - width of ones, derived from WIDTH
//
//  Ports       : clk      in   rising-edge clock
//                rst_n    in   synchronous active-low reset
//                set      in   [WIDTH]  per-channel set request
//                reset    in   [WIDTH]  per-channel reset request
//                clear    in   global synchronous clear
//                q        out  [WIDTH]  channel state
//                rise     out  [WIDTH]  0->1 pulse, aligned with q
//                fall     out  [WIDTH]  1->0 pulse, aligned with q
//                conflict out  [WIDTH]  set and reset both seen
//                ones     out  [CNT_W]  popcount(q), aligned with q
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_flop_bank #(
    parameter int WIDTH      = 8,
    parameter int SIMUL_MODE = 1,
    parameter int CNT_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] reset,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] ones
);

    localparam int c_MODE_SET    = 1;
    localparam int c_MODE_RESET  = 2;
    localparam int c_MODE_TOGGLE = 3;

    logic [WIDTH-1:0] r_state_q;
    logic [WIDTH-1:0] r_rise_q;
    logic [WIDTH-1:0] r_fall_q;
    logic [WIDTH-1:0] r_conflict_q;
    logic [CNT_W-1:0] r_ones_q;

    logic [WIDTH-1:0] w_simul;
    logic [WIDTH-1:0] w_chan_next;
    logic [WIDTH-1:0] w_state_d;
    logic [WIDTH-1:0] w_rise_d;
    logic [WIDTH-1:0] w_fall_d;
    logic [WIDTH-1:0] w_conflict_d;
    logic [CNT_W-1:0] w_ones_d;

    // Value a channel takes when set and reset arrive together; the mode is
    // fixed at elaboration so only one branch produces hardware.
    generate
        if (SIMUL_MODE == c_MODE_SET) begin : g_simul_set
            assign w_simul = {WIDTH{1'b1}};
        end else if (SIMUL_MODE == c_MODE_RESET) begin : g_simul_reset
            assign w_simul = {WIDTH{1'b0}};
        end else if (SIMUL_MODE == c_MODE_TOGGLE) begin : g_simul_toggle
            assign w_simul = ~r_state_q;
        end else begin : g_simul_hold
            assign w_simul = r_state_q;
        end
    endgenerate

    always_comb begin
        w_chan_next = ( set & ~reset)
                    | (~set & ~reset & r_state_q)
                    | ( set &  reset & w_simul);

        w_state_d    = clear ? {WIDTH{1'b0}} : w_chan_next;
        w_conflict_d = clear ? {WIDTH{1'b0}} : (set & reset);

        // Edges come from the next state, so under clear fall reports every
        // channel that was set and rise is necessarily zero.
        w_rise_d = ~r_state_q &  w_state_d;
        w_fall_d =  r_state_q & ~w_state_d;

        w_ones_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones_d = w_ones_d + CNT_W'(w_state_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q    <= '0;
            r_rise_q     <= '0;
            r_fall_q     <= '0;
            r_conflict_q <= '0;
            r_ones_q     <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_rise_q     <= w_rise_d;
            r_fall_q     <= w_fall_d;
            r_conflict_q <= w_conflict_d;
            r_ones_q     <= w_ones_d;
        end
    end

    assign q        = r_state_q;
    assign rise     = r_rise_q;
    assign fall     = r_fall_q;
    assign conflict = r_conflict_q;
    assign ones     = r_ones_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_flop_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_flop_bank
//  Description : Scoreboard bench for sr_flop_bank. Six instances share one
//                stimulus stream: WIDTH=8 in modes 0..3 (ids 0..3), WIDTH=1
//                (id 4) and WIDTH=64 (id 5), the latter two in mode 1. Each
//                step may queue hand-computed expected outputs for one
//                instance; a monitor pops them after the following edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_flop_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [63:0] set_v;
    logic [63:0] reset_v;

    always #5 clk = ~clk;

    logic [7:0] q8 [4];
    logic [7:0] rise8 [4];
    logic [7:0] fall8 [4];
    logic [7:0] conf8 [4];
    logic [3:0] ones8 [4];

    generate
        for (genvar m = 0; m < 4; m++) begin : g_mode
            sr_flop_bank #(.WIDTH(8), .SIMUL_MODE(m)) u_dut (
                .clk(clk), .rst_n(rst_n), .set(set_v[7:0]), .reset(reset_v[7:0]),
                .clear(clear), .q(q8[m]), .rise(rise8[m]), .fall(fall8[m]),
                .conflict(conf8[m]), .ones(ones8[m])
            );
        end
    endgenerate

    logic       q1, rise1, fall1, conf1;
    logic [0:0] ones1;
    sr_flop_bank #(.WIDTH(1), .SIMUL_MODE(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .set(set_v[0:0]), .reset(reset_v[0:0]),
        .clear(clear), .q(q1), .rise(rise1), .fall(fall1),
        .conflict(conf1), .ones(ones1)
    );

    logic [63:0] q64, rise64, fall64, conf64;
    logic [6:0]  ones64;
    sr_flop_bank #(.WIDTH(64), .SIMUL_MODE(1)) u_w64 (
        .clk(clk), .rst_n(rst_n), .set(set_v), .reset(reset_v),
        .clear(clear), .q(q64), .rise(rise64), .fall(fall64),
        .conflict(conf64), .ones(ones64)
    );

    typedef struct {
        int          dut;
        string       name;
        logic [63:0] q;
        logic [63:0] rise;
        logic [63:0] fall;
        logic [63:0] conf;
        logic [6:0]  ones;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: every edge, compare the oldest queued expectation.
    initial begin : p_monitor
        exp_t        e;
        logic [63:0] aq, ar, af, ac;
        logic [6:0]  ao;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                aq = '0; ar = '0; af = '0; ac = '0; ao = '0;
                case (e.dut)
                    0, 1, 2, 3: begin
                        aq = {56'd0, q8[e.dut]};    ar = {56'd0, rise8[e.dut]};
                        af = {56'd0, fall8[e.dut]}; ac = {56'd0, conf8[e.dut]};
                        ao = {3'd0, ones8[e.dut]};
                    end
                    4: begin
                        aq = {63'd0, q1};    ar = {63'd0, rise1};
                        af = {63'd0, fall1}; ac = {63'd0, conf1};
                        ao = {6'd0, ones1};
                    end
                    default: begin
                        aq = q64; ar = rise64; af = fall64; ac = conf64; ao = ones64;
                    end
                endcase
                total++;
                if (aq !== e.q || ar !== e.rise || af !== e.fall ||
                    ac !== e.conf || ao !== e.ones) begin
                    bad++;
                    $display("FAIL %s dut=%0d got q=%h rise=%h fall=%h conf=%h ones=%0d want q=%h rise=%h fall=%h conf=%h ones=%0d",
                             e.name, e.dut, aq, ar, af, ac, ao,
                             e.q, e.rise, e.fall, e.conf, e.ones);
                end
            end
        end
    end

    // Drive one cycle of inputs and, if chk, queue the outputs expected after
    // the following rising edge.
    task automatic step(input logic rn, input logic clr,
                        input logic [63:0] s, input logic [63:0] r,
                        input bit chk, input int dut, input string name,
                        input logic [63:0] eq, input logic [63:0] er,
                        input logic [63:0] ef, input logic [63:0] ec,
                        input logic [6:0] eo);
        exp_t e;
        @(negedge clk);
        rst_n   = rn;
        clear   = clr;
        set_v   = s;
        reset_v = r;
        if (chk) begin
            e.dut = dut; e.name = name;
            e.q = eq; e.rise = er; e.fall = ef; e.conf = ec; e.ones = eo;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input int dut);
        step(1'b0, 1'b0, '0, '0, 1'b1, dut, "reset_state", '0, '0, '0, '0, 7'd0);
    endtask

    // Scenario 1 on channel 0: (set,reset) = 00,10,00,01,00.
    task automatic latch_seq(input int dut);
        do_reset(dut);
        step(1'b1, 1'b0, 64'd0, 64'd0, 1'b1, dut, "latch_idle0", 64'd0, 64'd0, 64'd0, 64'd0, 7'd0);
        step(1'b1, 1'b0, 64'd1, 64'd0, 1'b1, dut, "latch_set",   64'd1, 64'd1, 64'd0, 64'd0, 7'd1);
        step(1'b1, 1'b0, 64'd0, 64'd0, 1'b1, dut, "latch_hold1", 64'd1, 64'd0, 64'd0, 64'd0, 7'd1);
        step(1'b1, 1'b0, 64'd0, 64'd1, 1'b1, dut, "latch_rst",   64'd0, 64'd0, 64'd1, 64'd0, 7'd0);
        step(1'b1, 1'b0, 64'd0, 64'd0, 1'b1, dut, "latch_hold0", 64'd0, 64'd0, 64'd0, 64'd0, 7'd0);
    endtask

    initial begin : p_stim
        logic [63:0] eq_t [3];
        logic [63:0] er_t [3];
        logic [63:0] ef_t [3];
        logic [6:0]  eo_t [3];
        int          guard;

        rst_n = 1'b0; clear = 1'b0; set_v = '0; reset_v = '0;
        do_reset(0);
        do_reset(5);

        latch_seq(1);
        latch_seq(4);
        latch_seq(5);

        // Simultaneous set+reset on channel 0 for three cycles, per mode.
        for (int m = 0; m < 4; m++) begin
            case (m)
                1: begin
                    eq_t = '{64'd1, 64'd1, 64'd1}; er_t = '{64'd1, 64'd0, 64'd0};
                    ef_t = '{64'd0, 64'd0, 64'd0}; eo_t = '{7'd1, 7'd1, 7'd1};
                end
                3: begin
                    eq_t = '{64'd1, 64'd0, 64'd1}; er_t = '{64'd1, 64'd0, 64'd1};
                    ef_t = '{64'd0, 64'd1, 64'd0}; eo_t = '{7'd1, 7'd0, 7'd1};
                end
                default: begin
                    eq_t = '{64'd0, 64'd0, 64'd0}; er_t = '{64'd0, 64'd0, 64'd0};
                    ef_t = '{64'd0, 64'd0, 64'd0}; eo_t = '{7'd0, 7'd0, 7'd0};
                end
            endcase
            do_reset(m);
            for (int c = 0; c < 3; c++) begin
                step(1'b1, 1'b0, 64'd1, 64'd1, 1'b1, m, "simul",
                     eq_t[c], er_t[c], ef_t[c], 64'd1, eo_t[c]);
            end
        end

        // Full bank set, then idle.
        do_reset(1);
        step(1'b1, 1'b0, 64'hFF, 64'd0, 1'b1, 1, "full_set",  64'hFF, 64'hFF, 64'd0, 64'd0, 7'd8);
        step(1'b1, 1'b0, 64'h00, 64'd0, 1'b1, 1, "full_idle", 64'hFF, 64'h00, 64'd0, 64'd0, 7'd8);

        // Clear beats a simultaneous set; conflicting request masked too.
        do_reset(1);
        step(1'b1, 1'b0, 64'hA5, 64'd0,  1'b1, 1, "pre_clear", 64'hA5, 64'hA5, 64'd0,  64'd0, 7'd4);
        step(1'b1, 1'b1, 64'h5A, 64'h01, 1'b1, 1, "clear",     64'h00, 64'h00, 64'hA5, 64'd0, 7'd0);

        // Reset in the middle of operation.
        do_reset(2);
        step(1'b1, 1'b0, 64'hFF, 64'd0, 1'b1, 2, "pre_rst",  64'hFF, 64'hFF, 64'd0, 64'd0, 7'd8);
        step(1'b0, 1'b0, 64'h0F, 64'd0, 1'b1, 2, "mid_rst",  64'h00, 64'h00, 64'd0, 64'd0, 7'd0);
        step(1'b1, 1'b0, 64'h0F, 64'd0, 1'b1, 2, "post_rst", 64'h0F, 64'h0F, 64'd0, 64'd0, 7'd4);

        // All 64 channels set on the wide instance.
        do_reset(5);
        step(1'b1, 1'b0, {64{1'b1}}, 64'd0, 1'b1, 5, "w64_all", {64{1'b1}}, {64{1'b1}}, 64'd0, 64'd0, 7'd64);
        step(1'b1, 1'b0, 64'd0, {64{1'b1}}, 1'b1, 5, "w64_clr", 64'd0, 64'd0, {64{1'b1}}, 64'd0, 7'd0);

        step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 0, "idle", '0, '0, '0, '0, 7'd0);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
